debounce_switch: RTL and testbench
==================================

# debounce_switch

Single-input mechanical-switch debouncer. It filters contact bounce on one raw push-button line and presents a clean level plus single-cycle edge strobes. One instance sits between each board button pin and the game logic; the player-movement block uses four of them, one per direction button. The player-movement block acts on the debounced release edge.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: number of consecutive clock cycles the input must differ from the current output before the output follows. 250000 is 10 ms at 25 MHz. Legal range is ≥ 1.
- `i_Clk` input 1: system clock. All logic is on the rising edge.
- `i_Rst_n` input 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `i_Switch` input 1: raw, asynchronous, bouncing switch level.
- `o_Switch` output 1: debounced level.
- `o_Rise` output 1: one-cycle strobe when `o_Switch` goes 0→1.
- `o_Fall` output 1: one-cycle strobe when `o_Switch` goes 1→0.

## Operation
- Internal sampled input `s_in`:
  - With the synchronizer compiled in, `s_in` is `i_Switch` passed through two flops.
  - Otherwise, `s_in` is `i_Switch` directly.
- State register `state` drives `o_Switch`.
- Counter `count` has width `$clog2(DEBOUNCE_LIMIT+1)` and never wraps.
- Each rising edge, in priority order:
  - `s_in == state`: `count <= 0`; `state` holds. Any bounce back to the current level restarts the qualification.
  - `s_in != state` and `count == DEBOUNCE_LIMIT-1`: `state <= s_in`; `count <= 0`.
  - Otherwise: `count <= count + 1`.
- Edge strobes:
  - `o_Rise <= 1` on the edge where `state` changes 0→1, else 0.
  - `o_Fall <= 1` on the edge where `state` changes 1→0, else 0.
  - `o_Rise` and `o_Fall` are never both high. Each is high for exactly one cycle per transition.
- `DEBOUNCE_LIMIT = 1`: every input change is accepted on the next edge (pure register).
- Reset asserted, at any time including mid-count: `state`, `count`, the sync flops, `o_Rise` and `o_Fall` all go to 0 immediately.
- After release: normal operation from the first rising edge. A switch held high through reset is reported as a rise after full qualification.

## Timing
- Reset values: `o_Switch = 0`, `o_Rise = 0`, `o_Fall = 0`.
- Latency without synchronizer:
  - `i_Switch` changes before edge k and stays stable.
  - `o_Switch` and the matching strobe update on edge k+`DEBOUNCE_LIMIT`-1, i.e. `DEBOUNCE_LIMIT` qualifying edges.
- Latency with synchronizer: 2 additional cycles.
- Glitch rejection: a pulse of fewer than `DEBOUNCE_LIMIT` sampled cycles never changes `o_Switch`.
- Strobes are aligned with the `o_Switch` change: they are high during the first cycle `o_Switch` shows the new level.
- No handshake. Output is a free-running level.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: a two-flop metastability synchronizer is inserted on `i_Switch`. Total latency is `DEBOUNCE_LIMIT+2` cycles.
- `DEBOUNCE_SYNC_EN` undefined: `i_Switch` feeds the comparator directly. Latency is `DEBOUNCE_LIMIT` cycles. Use this only when the input is already synchronous.

## Test plan
All scenarios use `DEBOUNCE_LIMIT = 4` with `DEBOUNCE_SYNC_EN` undefined unless stated.
- Reset, then hold `i_Switch = 0` for 20 cycles → `o_Switch`, `o_Rise` and `o_Fall` stay 0 throughout.
- Step `i_Switch` 0→1 and hold → `o_Switch` goes 1 on the 4th edge after the step. `o_Rise` is 1 for exactly that cycle. `o_Fall` stays 0.
- Bounce pattern 1,1,1,0,1,1,1,0 (each 1 cycle) on a stable-low output → `o_Switch` stays 0 and no strobes are produced.
- From `o_Switch = 1`, drop the input to 0 and hold → `o_Switch` goes 0 after 4 edges, with a single-cycle `o_Fall`.
- Assert `i_Rst_n = 0` while `count = 3` with the input high, mid-clock → `o_Switch = 0` at once. After release, 4 more edges of high are required before `o_Rise`.
- `DEBOUNCE_SYNC_EN` defined, step 0→1 → `o_Switch` rises on the 6th edge after the step.

Source files
------------

// File: rtl/debounce_switch.sv
// Single-input switch debouncer: clean level plus one-cycle rise/fall strobes.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on i_Switch.
module debounce_switch #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(DEBOUNCE_LIMIT - 1);

    logic          w_s_in;
    logic          r_state;
    logic [CW-1:0] r_count;
    logic          r_rise;
    logic          r_fall;

`ifdef DEBOUNCE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s_in = r_sync2;
`else
    assign w_s_in = i_Switch;
`endif

    // Any sample matching the current level restarts qualification; the counter
    // saturates at LIMIT-1 because the level flips and clears it on that edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= 1'b0;
            r_count <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s_in == r_state) begin
                r_count <= '0;
            end else if (r_count == LIMIT_M1) begin
                r_state <= w_s_in;
                r_count <= '0;
                r_rise  <= w_s_in;
                r_fall  <= ~w_s_in;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_Switch = r_state;
    assign o_Rise   = r_rise;
    assign o_Fall   = r_fall;

endmodule

// File: tb/tb_debounce_switch.sv
// Scoreboard bench for debounce_switch: a LIMIT=4 instance and a LIMIT=1
// instance share one stimulus stream and are checked against a sample-history model.
module tb_debounce_switch;

    localparam int LIMIT = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    typedef struct {
        logic sw;
        logic rise;
        logic fall;
        logic sw1;
        logic rise1;
        logic fall1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic o_sw, o_rise, o_fall;
    logic o_sw1, o_rise1, o_fall1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t exp_q[$];
    logic raw[$];
    logic samples[$];
    logic m_out = 1'b0;
    logic m_out1 = 1'b0;

    debounce_switch #(.DEBOUNCE_LIMIT(LIMIT)) u_dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Switch(sw),
        .o_Switch(o_sw),
        .o_Rise  (o_rise),
        .o_Fall  (o_fall)
    );

    debounce_switch #(.DEBOUNCE_LIMIT(1)) u_dut1 (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Switch(sw),
        .o_Switch(o_sw1),
        .o_Rise  (o_rise1),
        .o_Fall  (o_fall1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // The level flips once the most recent L sampled inputs all disagree with it.
    function automatic logic flips(input int l, input logic cur);
        if (samples.size() < l) return 1'b0;
        for (int i = 0; i < l; i++)
            if (samples[samples.size() - 1 - i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge rst_n) begin
        exp_q.delete();
        raw.delete();
        samples.delete();
        m_out  = 1'b0;
        m_out1 = 1'b0;
    end

    always @(posedge clk) begin
        exp_t e;
        logic s;
        e = '{sw: 1'b0, rise: 1'b0, fall: 1'b0, sw1: 1'b0, rise1: 1'b0, fall1: 1'b0};
        if (rst_n) begin
            raw.push_back(sw);
            if (SYNC == 0) s = sw;
            else s = (raw.size() > 2) ? raw[raw.size() - 3] : 1'b0;
            samples.push_back(s);
            if (raw.size() > 8) void'(raw.pop_front());
            if (samples.size() > 16) void'(samples.pop_front());
            if (flips(LIMIT, m_out)) begin
                m_out  = ~m_out;
                e.rise = m_out;
                e.fall = ~m_out;
            end
            if (flips(1, m_out1)) begin
                m_out1  = ~m_out1;
                e.rise1 = m_out1;
                e.fall1 = ~m_out1;
            end
            e.sw  = m_out;
            e.sw1 = m_out1;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_sw",    o_sw,    e.sw);
            chk("sb_rise",  o_rise,  e.rise);
            chk("sb_fall",  o_fall,  e.fall);
            chk("sb_sw1",   o_sw1,   e.sw1);
            chk("sb_rise1", o_rise1, e.rise1);
            chk("sb_fall1", o_fall1, e.fall1);
        end
    end

    task automatic drive(input logic v);
        @(posedge clk);
        #2;
        sw = v;
    endtask

    // Waits for a strobe on the LIMIT instance and checks the edge it landed on.
    task automatic wait_strobe(input logic want_fall, input int exp_edge, input string name);
        int seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if ((want_fall ? o_fall : o_rise) === 1'b1) seen = cyc;
        end
        chk_int(name, seen, exp_edge);
    endtask

    initial begin
        int k;
        int glitch;
        logic [7:0] pat;
        logic v;
        int len;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_sw", o_sw, 1'b0);
        chk("reset_rise", o_rise, 1'b0);
        chk("reset_fall", o_fall, 1'b0);
        rst_n = 1'b1;
        repeat (20) drive(1'b0);

        drive(1'b1);
        k = cyc + 1;
        wait_strobe(1'b0, k + LIMIT - 1 + SYNC, "rise_latency");
        repeat (5) @(posedge clk);

        drive(1'b0);
        k = cyc + 1;
        wait_strobe(1'b1, k + LIMIT - 1 + SYNC, "fall_latency");
        repeat (6) drive(1'b0);

        pat = 8'b11101110;
        glitch = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i < 8 ? pat[7 - i] : 1'b0);
            @(negedge clk);
            if (o_sw !== 1'b0 || o_rise !== 1'b0 || o_fall !== 1'b0) glitch++;
        end
        chk_int("bounce_rejected", glitch, 0);

        drive(1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcount_rst_sw", o_sw, 1'b0);
        chk("midcount_rst_rise", o_rise, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        k = cyc + 1;
        wait_strobe(1'b0, k + LIMIT - 1 + SYNC, "rise_after_rst");

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_high_sw", o_sw, 1'b0);
        chk("rst_high_sw1", o_sw1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int r = 0; r < 300; r++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * LIMIT + 3);
            repeat (len) drive(v);
            if ($urandom_range(0, 49) == 0) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        end

        repeat (12) drive(1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
